// File: rtl/sap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sap_ctrl_pkg
// Shared definitions for the SAP control sequencer: the fixed opcode map,
// FSM state codes, the packed control word driven into the datapath, and the
// control word's inactive (reset) value.
// -----------------------------------------------------------------------------
package sap_ctrl_pkg;

    // Opcode map (4-bit). A..E are illegal and run as NOP.
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_OUT  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_SUBI = 4'h7;
    localparam logic [3:0] OP_CMP  = 4'h8;
    localparam logic [3:0] OP_SKZ  = 4'h9;
    localparam logic [3:0] OP_HLT  = 4'hF;

    // Sequencer states.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_EX1  = 3'd1;
    localparam state_t ST_EX2  = 3'd2;
    localparam state_t ST_DONE = 3'd3;
    localparam state_t ST_HALT = 3'd4;

    // Control word presented to the datapath. Load strobes are active low.
    typedef struct packed {
        logic bus_in_en;
        logic n_load_a;
        logic n_load_b;
        logic en_a;
        logic en_alu;
        logic alu_sub;
    } ctrl_t;

    // Nothing drives the bus, nothing loads.
    localparam ctrl_t CTRL_IDLE = '{
        bus_in_en: 1'b0,
        n_load_a:  1'b1,
        n_load_b:  1'b1,
        en_a:      1'b0,
        en_alu:    1'b0,
        alu_sub:   1'b0
    };

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'hA) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/sap_ctrl_if.sv
// -----------------------------------------------------------------------------
// sap_ctrl_if
// Instruction handshake between an instruction source and the sequencer.
//   instr_valid  source -> seq   opcode offered
//   instr_op     source -> seq   4-bit opcode, sampled only on accept
//   instr_ready  seq -> source   sequencer can accept this cycle
//   done         seq -> source   one-cycle pulse per retired instruction
// -----------------------------------------------------------------------------
interface sap_ctrl_if;
    logic       instr_valid;
    logic [3:0] instr_op;
    logic       instr_ready;
    logic       done;

    modport master (
        output instr_valid,
        output instr_op,
        input  instr_ready,
        input  done
    );

    modport slave (
        input  instr_valid,
        input  instr_op,
        output instr_ready,
        output done
    );
endinterface

// File: rtl/sap_ctrl_decode.sv
// -----------------------------------------------------------------------------
// sap_ctrl_decode
// Pure combinational microcode: from the current state, the opcode in play,
// the pending-skip flag and the zero flag, produce the next state, the control
// word for the next cycle, and the set requests for the sticky err/skip flags.
//   state      in   current FSM state
//   op         in   opcode in play (incoming opcode in IDLE, IR otherwise)
//   skip       in   pending skip: the opcode in play is treated as NOP
//   accept     in   handshake fires this cycle
//   zf         in   datapath zero flag
//   nxt_state  out  next FSM state
//   nxt_ctrl   out  control word to register for the next cycle
//   set_err    out  illegal opcode reached EX1
//   set_skip   out  SKZ saw zf=1 in EX1
// -----------------------------------------------------------------------------
module sap_ctrl_decode
    import sap_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] op,
    input  logic       skip,
    input  logic       accept,
    input  logic       zf,
    output state_t     nxt_state,
    output ctrl_t      nxt_ctrl,
    output logic       set_err,
    output logic       set_skip
);

    logic [3:0] eff_op;

    // A skipped instruction is a NOP in every respect, including HLT and
    // illegal codes (no halt, no err).
    assign eff_op = skip ? OP_NOP : op;

    // First execute step. ADDI/SUBI begin with the LDB step.
    function automatic ctrl_t ex1_word(input logic [3:0] o);
        ctrl_t w;
        w = CTRL_IDLE;
        case (o)
            OP_LDA: begin
                w.bus_in_en = 1'b1;
                w.n_load_a  = 1'b0;
            end
            OP_LDB, OP_ADDI, OP_SUBI: begin
                w.bus_in_en = 1'b1;
                w.n_load_b  = 1'b0;
            end
            OP_ADD: begin
                w.en_alu   = 1'b1;
                w.n_load_a = 1'b0;
            end
            OP_SUB: begin
                w.en_alu   = 1'b1;
                w.alu_sub  = 1'b1;
                w.n_load_a = 1'b0;
            end
            OP_OUT: w.en_a = 1'b1;
            OP_CMP: begin
                w.en_alu  = 1'b1;
                w.alu_sub = 1'b1;
            end
            default: w = CTRL_IDLE;
        endcase
        return w;
    endfunction

    // Second execute step, only used by the immediate forms.
    function automatic ctrl_t ex2_word(input logic [3:0] o);
        ctrl_t w;
        case (o)
            OP_ADDI: w = ex1_word(OP_ADD);
            OP_SUBI: w = ex1_word(OP_SUB);
            default: w = CTRL_IDLE;
        endcase
        return w;
    endfunction

    always_comb begin
        nxt_state = state;
        nxt_ctrl  = CTRL_IDLE;
        set_err   = 1'b0;
        set_skip  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    nxt_state = ST_EX1;
                    nxt_ctrl  = ex1_word(eff_op);
                end
            end
            ST_EX1: begin
                set_err  = is_illegal(eff_op);
                set_skip = (eff_op == OP_SKZ) && zf;
                if ((eff_op == OP_ADDI) || (eff_op == OP_SUBI)) begin
                    nxt_state = ST_EX2;
                    nxt_ctrl  = ex2_word(eff_op);
                end else if (eff_op == OP_HLT) begin
                    nxt_state = ST_HALT;
                end else begin
                    nxt_state = ST_DONE;
                end
            end
            ST_EX2:  nxt_state = ST_DONE;
            ST_DONE: nxt_state = ST_IDLE;
            ST_HALT: nxt_state = ST_HALT;
            default: nxt_state = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// -----------------------------------------------------------------------------
// sap_control_sequencer
// Microcoded control sequencer for the bus-based adder/accumulator datapath.
// Accepts opcodes over a valid/ready handshake and issues one registered
// control word per cycle.
//   clk, rst_n     clock, asynchronous active-low reset
//   bus (slave)    instr_valid/instr_op in, instr_ready/done out
//   zf_in, cf_in   datapath flags (cf_in reserved)
//   bus_in_en, n_load_a, n_load_b, en_a, en_alu, alu_sub   control word
//   halted         HLT executed, held until reset
//   err            sticky illegal-opcode flag
// All control outputs and done come straight from flops, so instr_* never
// reaches an output combinationally.
// -----------------------------------------------------------------------------
module sap_control_sequencer
    import sap_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    sap_ctrl_if.slave   bus,
    input  logic        zf_in,
    input  logic        cf_in,
    output logic        bus_in_en,
    output logic        n_load_a,
    output logic        n_load_b,
    output logic        en_a,
    output logic        en_alu,
    output logic        alu_sub,
    output logic        halted,
    output logic        err
);

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic [3:0] ir_q, ir_d;
    logic       skip_q, skip_d;
    logic       err_q, err_d;
    logic       halted_q, halted_d;
    logic       done_q, done_d;

    state_t     nxt_state;
    ctrl_t      nxt_ctrl;
    logic       set_err;
    logic       set_skip;
    logic       accept;
    logic [3:0] op_sel;

    // Carry is reserved for future conditional ops.
    logic       cf_unused;
    assign cf_unused = cf_in;

    // HALT is its own state, so IDLE alone implies "not halted".
    assign bus.instr_ready = (state_q == ST_IDLE);
    assign accept          = bus.instr_valid && bus.instr_ready;

    // In IDLE the EX1 word must be registered on the accept edge itself,
    // before IR holds the opcode, so decode the incoming opcode directly.
    assign op_sel = (state_q == ST_IDLE) ? bus.instr_op : ir_q;

    sap_ctrl_decode u_decode (
        .state     (state_q),
        .op        (op_sel),
        .skip      (skip_q),
        .accept    (accept),
        .zf        (zf_in),
        .nxt_state (nxt_state),
        .nxt_ctrl  (nxt_ctrl),
        .set_err   (set_err),
        .set_skip  (set_skip)
    );

    always_comb begin
        state_d  = nxt_state;
        ctrl_d   = nxt_ctrl;
        ir_d     = accept ? bus.instr_op : ir_q;
        // skip lives exactly until the end of the next instruction's EX1;
        // the same EX1 may re-arm it if that instruction is itself SKZ.
        skip_d   = (state_q == ST_EX1) ? set_skip : skip_q;
        err_d    = err_q | set_err;
        halted_d = halted_q | (nxt_state == ST_HALT);
        done_d   = (nxt_state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= CTRL_IDLE;
            ir_q     <= OP_NOP;
            skip_q   <= 1'b0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            ir_q     <= ir_d;
            skip_q   <= skip_d;
            err_q    <= err_d;
            halted_q <= halted_d;
            done_q   <= done_d;
        end
    end

    assign bus.done  = done_q;
    assign bus_in_en = ctrl_q.bus_in_en;
    assign n_load_a  = ctrl_q.n_load_a;
    assign n_load_b  = ctrl_q.n_load_b;
    assign en_a      = ctrl_q.en_a;
    assign en_alu    = ctrl_q.en_alu;
    assign alu_sub   = ctrl_q.alu_sub;
    assign halted    = halted_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for sap_control_sequencer: reset values, a table of single opcodes,
// hand-written multi-cycle sequences (held valid, skip, halt, async reset),
// and a random opcode stream against a behavioural model.
// -----------------------------------------------------------------------------
module tb_sap_control_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic zf_in = 1'b0;
    logic cf_in = 1'b0;
    logic bus_in_en, n_load_a, n_load_b, en_a, en_alu, alu_sub, halted, err;

    sap_ctrl_if bus ();

    sap_control_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .zf_in     (zf_in),
        .cf_in     (cf_in),
        .bus_in_en (bus_in_en),
        .n_load_a  (n_load_a),
        .n_load_b  (n_load_b),
        .en_a      (en_a),
        .en_alu    (en_alu),
        .alu_sub   (alu_sub),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Control words as {bus_in_en, n_load_a, n_load_b, en_a, en_alu, alu_sub}.
    localparam logic [5:0] W_IDLE = 6'b011000;
    localparam logic [5:0] W_LDA  = 6'b101000;
    localparam logic [5:0] W_LDB  = 6'b110000;
    localparam logic [5:0] W_ADD  = 6'b001010;
    localparam logic [5:0] W_SUB  = 6'b001011;
    localparam logic [5:0] W_OUT  = 6'b011100;
    localparam logic [5:0] W_CMP  = 6'b011011;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [5:0] cw();
        return {bus_in_en, n_load_a, n_load_b, en_a, en_alu, alu_sub};
    endfunction

    // Per-instruction trace; index j = sample at the falling edge after
    // accept edge k+j.
    logic [5:0] tr_cw [4];
    logic [3:0] tr_done, tr_rdy, tr_halt;
    logic       tr_err;

    task automatic issue(input logic [3:0] op, input logic zf);
        int n = 0;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) begin
            chk("ready_wait_timeout", 64'd0, 64'd1);
            return;
        end
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        zf_in           = zf;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instr_op    = 4'($urandom);   // opcode must only matter on accept
        for (int j = 0; j < 4; j++) begin
            tr_cw[j]   = cw();
            tr_done[j] = bus.done;
            tr_rdy[j]  = bus.instr_ready;
            tr_halt[j] = halted;
            if (j < 3) @(negedge clk);
        end
        tr_err = err;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Bus exclusivity / accept / done bookkeeping, sampled 1 after the
    // falling edge so both DUT outputs and bench drives are settled.
    int  viol = 0, acc_cnt = 0, done_cnt = 0;
    bit  mon_on = 1'b0;
    bit  acc_pre = 1'b0;
    always @(negedge clk) begin
        #1;
        acc_pre = rst_n && bus.instr_valid && bus.instr_ready;
        if (rst_n) begin
            if ((int'(bus_in_en) + int'(en_a) + int'(en_alu)) > 1) viol++;
            if (!n_load_a && !n_load_b) viol++;
            if (mon_on && bus.done) done_cnt++;
        end
    end
    always @(posedge clk) if (mon_on && acc_pre && rst_n) acc_cnt++;

    // Reference model: what one instruction should look like, from the
    // opcode table and the cycle counts (3 normal, 4 immediate, HLT halts).
    function automatic logic [5:0] m_w0(input logic [3:0] o);
        case (o)
            4'h1:             return W_LDA;
            4'h2, 4'h6, 4'h7: return W_LDB;
            4'h3:             return W_ADD;
            4'h4:             return W_SUB;
            4'h5:             return W_OUT;
            4'h8:             return W_CMP;
            default:          return W_IDLE;
        endcase
    endfunction

    function automatic logic [5:0] m_w1(input logic [3:0] o);
        if (o == 4'h6) return W_ADD;
        if (o == 4'h7) return W_SUB;
        return W_IDLE;
    endfunction

    typedef struct {
        logic [3:0] op;
        logic       zf;
        logic [5:0] w0, w1;
        logic [3:0] dn, rd;
        logic       er;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] op, eff;
        logic       zf;
        logic       m_skip, m_err;
        int         halts, acc, dn, dbl;
        logic       prevd;
        logic [63:0] got, expv;

        tbl[0]  = '{4'h0, 1'b0, W_IDLE, W_IDLE, 4'b0010, 4'b1100, 1'b0};
        tbl[1]  = '{4'h1, 1'b0, W_LDA,  W_IDLE, 4'b0010, 4'b1100, 1'b0};
        tbl[2]  = '{4'h2, 1'b0, W_LDB,  W_IDLE, 4'b0010, 4'b1100, 1'b0};
        tbl[3]  = '{4'h3, 1'b0, W_ADD,  W_IDLE, 4'b0010, 4'b1100, 1'b0};
        tbl[4]  = '{4'h4, 1'b0, W_SUB,  W_IDLE, 4'b0010, 4'b1100, 1'b0};
        tbl[5]  = '{4'h5, 1'b0, W_OUT,  W_IDLE, 4'b0010, 4'b1100, 1'b0};
        tbl[6]  = '{4'h8, 1'b0, W_CMP,  W_IDLE, 4'b0010, 4'b1100, 1'b0};
        tbl[7]  = '{4'h9, 1'b0, W_IDLE, W_IDLE, 4'b0010, 4'b1100, 1'b0};
        tbl[8]  = '{4'h6, 1'b1, W_LDB,  W_ADD,  4'b0100, 4'b1000, 1'b0};
        tbl[9]  = '{4'h7, 1'b0, W_LDB,  W_SUB,  4'b0100, 4'b1000, 1'b0};
        tbl[10] = '{4'hC, 1'b0, W_IDLE, W_IDLE, 4'b0010, 4'b1100, 1'b1};
        tbl[11] = '{4'h1, 1'b0, W_LDA,  W_IDLE, 4'b0010, 4'b1100, 1'b1};
        tbl[12] = '{4'hA, 1'b0, W_IDLE, W_IDLE, 4'b0010, 4'b1100, 1'b1};
        tbl[13] = '{4'hE, 1'b0, W_IDLE, W_IDLE, 4'b0010, 4'b1100, 1'b1};

        bus.instr_valid = 1'b0;
        bus.instr_op    = 4'h0;

        // Reset values while rst_n is held low.
        repeat (2) @(negedge clk);
        chk("rst_ready",  bus.instr_ready, 1'b1);
        chk("rst_done",   bus.done, 1'b0);
        chk("rst_ctrl",   cw(), W_IDLE);
        chk("rst_halted", halted, 1'b0);
        chk("rst_err",    err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of single instructions; err goes sticky from the C row on.
        for (int i = 0; i < 14; i++) begin
            issue(tbl[i].op, tbl[i].zf);
            chk($sformatf("vec%0d_ex1",   i), tr_cw[0], tbl[i].w0);
            chk($sformatf("vec%0d_ex2",   i), tr_cw[1], tbl[i].w1);
            chk($sformatf("vec%0d_done",  i), tr_done,  tbl[i].dn);
            chk($sformatf("vec%0d_ready", i), tr_rdy,   tbl[i].rd);
            chk($sformatf("vec%0d_err",   i), tr_err,   tbl[i].er);
            chk($sformatf("vec%0d_halt",  i), tr_halt,  4'b0000);
        end
        do_reset();
        chk("err_cleared_by_reset", err, 1'b0);

        // ADDI back-to-back with instr_valid held: one accept per 4 cycles.
        bus.instr_valid = 1'b1;
        bus.instr_op    = 4'h6;
        acc = 0; dn = 0; dbl = 0; prevd = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (bus.instr_ready) acc++;
            if (bus.done) dn++;
            if (bus.done && prevd) dbl++;
            prevd = bus.done;
            if (c == 1) chk("addi_hold_ex1", cw(), W_LDB);
            if (c == 2) chk("addi_hold_ex2", cw(), W_ADD);
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        chk("addi_hold_accepts", acc, 4);
        chk("addi_hold_dones",   dn, 4);
        chk("addi_hold_done_1cyc", dbl, 0);

        // SKZ taken: the following HLT is a NOP.
        issue(4'h9, 1'b1);
        issue(4'hF, 1'b0);
        chk("skz_hlt_halted", tr_halt, 4'b0000);
        chk("skz_hlt_done",   tr_done, 4'b0010);
        chk("skz_hlt_ctrl",   tr_cw[0], W_IDLE);
        // SKZ taken: an illegal opcode does not raise err.
        issue(4'h9, 1'b1);
        issue(4'hC, 1'b0);
        chk("skz_illegal_err", tr_err, 1'b0);
        // Skip is consumed; the next op executes normally.
        issue(4'h1, 1'b0);
        chk("skip_consumed_lda", tr_cw[0], W_LDA);
        // SKZ not taken: HLT halts.
        issue(4'h9, 1'b0);
        issue(4'hF, 1'b0);
        chk("hlt_halted", tr_halt, 4'b1110);
        chk("hlt_ready",  tr_rdy,  4'b0000);
        chk("hlt_done",   tr_done, 4'b0000);
        bus.instr_valid = 1'b1;
        bus.instr_op    = 4'h1;
        repeat (5) @(negedge clk);
        chk("halt_ready_stays0", bus.instr_ready, 1'b0);
        chk("halt_ctrl_idle",    cw(), W_IDLE);
        chk("halt_still_halted", halted, 1'b1);
        bus.instr_valid = 1'b0;
        do_reset();
        chk("halt_cleared_ready",  bus.instr_ready, 1'b1);
        chk("halt_cleared_halted", halted, 1'b0);

        // Asynchronous reset in the middle of SUBI's EX2.
        bus.instr_valid = 1'b1;
        bus.instr_op    = 4'h7;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("subi_ex2_before_rst", cw(), W_SUB);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl",  cw(), W_IDLE);
        chk("async_rst_ready", bus.instr_ready, 1'b1);
        chk("async_rst_done",  bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(4'h1, 1'b0);
        chk("post_rst_lda_ex1",  tr_cw[0], W_LDA);
        chk("post_rst_lda_done", tr_done,  4'b0010);

        // Random stream against the model.
        do_reset();
        m_skip = 1'b0; m_err = 1'b0; halts = 0;
        acc_cnt = 0; done_cnt = 0; mon_on = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            op  = 4'($urandom);
            zf  = 1'($urandom);
            eff = m_skip ? 4'h0 : op;
            m_err = m_err | ((eff >= 4'hA) && (eff <= 4'hE));
            expv = {22'd0, m_w0(eff), m_w1(eff),
                    (eff == 4'hF) ? 4'b0000 : (eff == 4'h6 || eff == 4'h7) ? 4'b0100 : 4'b0010,
                    (eff == 4'hF) ? 4'b0000 : (eff == 4'h6 || eff == 4'h7) ? 4'b1000 : 4'b1100,
                    (eff == 4'hF) ? 4'b1110 : 4'b0000,
                    m_err};
            issue(op, zf);
            got = {22'd0, tr_cw[0], tr_cw[1], tr_done, tr_rdy, tr_halt, tr_err};
            chk($sformatf("rand%0d_op%0h", i, op), got, expv);
            m_skip = (eff == 4'h9) && zf;
            if (eff == 4'hF) begin
                halts++;
                do_reset();
                m_skip = 1'b0;
                m_err  = 1'b0;
            end
        end
        @(negedge clk);
        mon_on = 1'b0;
        chk("done_eq_accept_minus_hlt", done_cnt, acc_cnt - halts);
        chk("rand_accepts", acc_cnt, 1000);
        chk("bus_exclusive_loads", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Microcoded control sequencer for the bus-based adder/accumulator datapath. It accepts 4-bit opcodes over a valid/ready handshake and issues the per-cycle control word the datapath consumes: input-bus drive, A/B load strobes, A output enable, ALU enable and subtract. It also reads back the datapath's carry and zero flags. It sits between the instruction source (host pins or a future program ROM) and the datapath, replacing direct pin control of the strobes.

## Interface
Parameters:
- none (opcode map fixed in package)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  opcode offered
- instr_op  in  4  opcode; sampled only on accept
- instr_ready  out  1  sequencer can accept (IDLE, not halted)
- done  out  1  one-cycle pulse per retired instruction
- zf_in  in  1  datapath zero flag
- cf_in  in  1  datapath carry flag; unused, reserved
- bus_in_en  out  1  external operand drives bus
- n_load_a  out  1  active-low A load
- n_load_b  out  1  active-low B load
- en_a  out  1  A drives bus
- en_alu  out  1  ALU drives bus
- alu_sub  out  1  ALU subtract select
- halted  out  1  HLT executed
- err  out  1  sticky illegal-opcode flag

## Operation
- Opcodes:
  - 0 NOP
  - 1 LDA: bus_in_en, n_load_a=0
  - 2 LDB: bus_in_en, n_load_b=0
  - 3 ADD: en_alu, n_load_a=0
  - 4 SUB: en_alu, alu_sub, n_load_a=0
  - 5 OUT: en_a
  - 6 ADDI: EX1 = LDB step, EX2 = ADD step
  - 7 SUBI: EX1 = LDB step, EX2 = SUB step
  - 8 CMP: en_alu, alu_sub, no load
  - 9 SKZ: no controls; if zf_in=1 in EX1, set skip
  - F HLT
  - A–E: illegal, executed as NOP, set err
- FSM states: IDLE, EX1, EX2, DONE, HALT.
  - IDLE→EX1 on instr_valid && instr_ready; the opcode is latched into an internal IR.
  - EX1→EX2 for ADDI/SUBI. EX1→HALT for HLT. Otherwise EX1→DONE.
  - EX2→DONE. DONE→IDLE unconditionally.
- Skip: when skip is set, the next accepted opcode executes as NOP regardless of value, including HLT and illegal codes. It does not set err. skip clears in that instruction's EX1.
- Bus exclusivity: at most one of bus_in_en, en_a, en_alu is high in any cycle. n_load_a and n_load_b are never both low.
- Operand data on the external input must be stable from the accept edge until done.
- Reset values: state IDLE, IR=0, skip=0, err=0, halted=0, instr_ready=1, done=0, n_load_a=n_load_b=1, all other controls 0.
- Reset mid-operation: all controls deassert immediately (asynchronous); the partial instruction is abandoned.
- HALT: instr_ready=0, halted=1, all controls inactive until reset.

## Timing
- Control outputs and done are registered. They update on the edge that enters the state, so there are no combinational paths from instr_* to outputs.
- instr_ready is decoded from state (IDLE and not HALT).
- Accept at edge k:
  - EX1 controls are valid from k until k+1; the datapath samples at k+1.
  - Single-step ops: DONE from k+1 to k+2; instr_ready returns at k+2. That is 3 cycles per instruction.
  - ADDI/SUBI: EX2 from k+1 to k+2; done from k+2 to k+3. That is 4 cycles.
  - HLT: halted rises at k+1. No done pulse.
- zf_in is sampled at the edge ending SKZ's EX1 and reflects the flags from the last ALU cycle.
- instr_valid held high across done does not double-accept. The next accept is no earlier than the edge following ready's return.

## Structure
- sap_ctrl_pkg:
  - opcode localparams
  - state enum
  - packed control-word struct {bus_in_en, n_load_a, n_load_b, en_a, en_alu, alu_sub}
  - CTRL_IDLE constant
- Sub-module sap_ctrl_decode: combinational (IR, step, skip) → next control word and next state.
- Top: registers, handshake, and sticky flags.

## Test plan
- Reset then LDA (op 1): ready=1 at reset. The cycle after accept shows bus_in_en=1, n_load_a=0. done pulses 2 cycles after accept; ready returns 3 cycles after accept.
- ADDI (op 6) back-to-back with instr_valid held: EX1 shows bus_in_en with n_load_b=0; EX2 shows en_alu with n_load_a=0. done is 1 cycle; exactly one accept per instruction.
- SKZ with zf_in=1 then HLT: HLT is discarded as NOP, halted stays 0, done pulses. Repeat with zf_in=0: halted=1, ready stays 0.
- Opcode C: executes as NOP with no controls asserted, err=1 and sticky across 3 later instructions, cleared only by rst_n.
- Assert rst_n=0 mid-EX2 of SUBI: controls return to reset values without waiting for a clock edge. After release, ready=1 and the next LDA runs normally.
- Random opcode stream (1000 ops): assertion checks that at most one bus driver is high per cycle, loads are never both active, and the done count equals the accept count minus the HLT count.
